// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller: state encoding,
// lamp patterns and a small elaboration-time helper.
package traffic_pkg;

   typedef enum logic [2:0] {
      ST_GREEN  = 3'd0,
      ST_YELLOW = 3'd1,
      ST_RED    = 3'd2,
      ST_PED    = 3'd3,
      ST_EMG    = 3'd4
   } state_e;

   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_RED    = 3'b100;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/traffic_light_fsm_timer.sv
// Phase timer: up-counter that restarts at zero on clear and flags when the
// count reaches the terminal value supplied by the controller.
module traffic_phase_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear_i,
   input  logic [W-1:0] terminal_i,
   output logic         done_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = clear_i ? '0 : count_q + {{(W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_o = (count_q == terminal_i);

endmodule

// File: rtl/traffic_light_fsm.sv
// Five-state traffic light controller with latched pedestrian/emergency requests.
// Define TRAFFIC_STATE_DBG_EN to expose dbg_state and dbg_ped_pending.
module traffic_light_fsm
   import traffic_pkg::*;
#(
   parameter int GREEN_CYCLES  = 100,
   parameter int YELLOW_CYCLES = 20,
   parameter int RED_CYCLES    = 80,
   parameter int PED_CYCLES    = 50,
   parameter int EMG_CYCLES    = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pedestrian_button,
   input  logic       emergency_button,
   output logic       pedestrian_light,
   output logic       emergency_light,
   output logic [2:0] traffic
`ifdef TRAFFIC_STATE_DBG_EN
   ,
   output logic [2:0] dbg_state,
   output logic       dbg_ped_pending
`endif
);

   localparam int MaxCycles = max_int(max_int(max_int(GREEN_CYCLES, YELLOW_CYCLES),
                                              max_int(RED_CYCLES, PED_CYCLES)),
                                      EMG_CYCLES);
   localparam int TW = $clog2(MaxCycles) + 1;

   state_e        state_q, state_d;
   logic          ped_req_q, ped_req_d;
   logic          emg_req_q, emg_req_d;
   logic          emg_restart;
   logic          timer_clear;
   logic          timer_done;
   logic [TW-1:0] terminal;
   logic [2:0]    traffic_q, traffic_d;
   logic          ped_light_q, ped_light_d;
   logic          emg_light_q, emg_light_d;

   traffic_phase_timer #(
      .W(TW)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (timer_clear),
      .terminal_i(terminal),
      .done_o    (timer_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_GREEN;
         ped_req_q   <= 1'b0;
         emg_req_q   <= 1'b0;
         traffic_q   <= LAMP_GREEN;
         ped_light_q <= 1'b0;
         emg_light_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ped_req_q   <= ped_req_d;
         emg_req_q   <= emg_req_d;
         traffic_q   <= traffic_d;
         ped_light_q <= ped_light_d;
         emg_light_q <= emg_light_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      emg_restart = 1'b0;

      case (state_q)
         ST_GREEN:  terminal = TW'(GREEN_CYCLES - 1);
         ST_YELLOW: terminal = TW'(YELLOW_CYCLES - 1);
         ST_RED:    terminal = TW'(RED_CYCLES - 1);
         ST_PED:    terminal = TW'(PED_CYCLES - 1);
         ST_EMG:    terminal = TW'(EMG_CYCLES - 1);
         default:   terminal = TW'(GREEN_CYCLES - 1);
      endcase

      // Emergency pre-empts every other phase; a press inside EMERGENCY extends it.
      if (state_q != ST_EMG && (emg_req_q || emergency_button)) begin
         state_d = ST_EMG;
      end else begin
         case (state_q)
            ST_GREEN:  if (timer_done) state_d = ST_YELLOW;
            ST_YELLOW: if (timer_done) state_d = ped_req_q ? ST_PED : ST_RED;
            ST_RED:    if (timer_done) state_d = ST_GREEN;
            ST_PED:    if (timer_done) state_d = ST_GREEN;
            ST_EMG: begin
               if (emergency_button) begin
                  emg_restart = 1'b1;
               end else if (timer_done) begin
                  state_d = ST_RED;
               end
            end
            default:   state_d = ST_GREEN;
         endcase
      end

      timer_clear = emg_restart || (state_d != state_q);

      // A press on the edge that enters PEDESTRIAN re-arms the request.
      ped_req_d = pedestrian_button ||
                  (ped_req_q && !(state_d == ST_PED && state_q != ST_PED));
      emg_req_d = (emergency_button || emg_req_q) && (state_d != ST_EMG);
   end

   always_comb begin
      traffic_d   = LAMP_GREEN;
      ped_light_d = 1'b0;
      emg_light_d = 1'b0;
      case (state_d)
         ST_YELLOW: traffic_d = LAMP_YELLOW;
         ST_RED:    traffic_d = LAMP_RED;
         ST_PED: begin
            traffic_d   = LAMP_RED;
            ped_light_d = 1'b1;
         end
         ST_EMG: begin
            traffic_d   = LAMP_RED;
            emg_light_d = 1'b1;
         end
         default: traffic_d = LAMP_GREEN;
      endcase
   end

   assign traffic          = traffic_q;
   assign pedestrian_light = ped_light_q;
   assign emergency_light  = emg_light_q;

`ifdef TRAFFIC_STATE_DBG_EN
   assign dbg_state       = state_q;
   assign dbg_ped_pending = ped_req_q;
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed testbench for traffic_light_fsm: each task replays one scenario cycle
// by cycle against hand-derived phase windows of {traffic, walk, beacon}.
module tb_traffic_light_fsm;

   logic       clk;
   logic       reset;
   logic       pedestrian_button;
   logic       emergency_button;
   logic       pedestrian_light;
   logic       emergency_light;
   logic [2:0] traffic;

   int checkCount;
   int errorCount;

   localparam logic [4:0] PH_G = 5'b001_0_0;
   localparam logic [4:0] PH_Y = 5'b010_0_0;
   localparam logic [4:0] PH_R = 5'b100_0_0;
   localparam logic [4:0] PH_P = 5'b100_1_0;
   localparam logic [4:0] PH_E = 5'b100_0_1;

   traffic_light_fsm dut (
      .clk              (clk),
      .reset            (reset),
      .pedestrian_button(pedestrian_button),
      .emergency_button (emergency_button),
      .pedestrian_light (pedestrian_light),
      .emergency_light  (emergency_light),
      .traffic          (traffic)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Interval 0 begins at the release of reset; the first edge after it ends interval 0.
   task automatic do_reset();
      pedestrian_button = 1'b0;
      emergency_button  = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      pedestrian_button = 1'b0;
      emergency_button  = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      checkCount++;
      if (traffic !== 3'b001) begin
         errorCount++;
         $display("[TB] FAIL reset_traffic: got %b expected 001", traffic);
      end
      checkCount++;
      if (pedestrian_light !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_ped_light: got %b expected 0", pedestrian_light);
      end
      checkCount++;
      if (emergency_light !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_emg_light: got %b expected 0", emergency_light);
      end
   endtask

   task automatic test_nominal();
      logic [4:0] exp;
      do_reset();
      for (int n = 0; n <= 200; n++) begin
         if (n < 100)      exp = PH_G;
         else if (n < 120) exp = PH_Y;
         else if (n < 200) exp = PH_R;
         else              exp = PH_G;
         checkCount++;
         if ({traffic, pedestrian_light, emergency_light} !== exp) begin
            errorCount++;
            $display("[TB] FAIL nominal cycle %0d: got %b expected %b", n,
                     {traffic, pedestrian_light, emergency_light}, exp);
         end
         tick();
      end
   endtask

   task automatic test_pedestrian();
      logic [4:0] exp;
      do_reset();
      for (int n = 0; n <= 370; n++) begin
         if (n < 100)      exp = PH_G;
         else if (n < 120) exp = PH_Y;
         else if (n < 170) exp = PH_P;
         else if (n < 270) exp = PH_G;
         else if (n < 290) exp = PH_Y;
         else if (n < 370) exp = PH_R;
         else              exp = PH_G;
         checkCount++;
         if ({traffic, pedestrian_light, emergency_light} !== exp) begin
            errorCount++;
            $display("[TB] FAIL pedestrian cycle %0d: got %b expected %b", n,
                     {traffic, pedestrian_light, emergency_light}, exp);
         end
         pedestrian_button = (n == 50);
         tick();
      end
      pedestrian_button = 1'b0;
   endtask

   task automatic test_emergency();
      logic [4:0] exp;
      do_reset();
      for (int n = 0; n <= 300; n++) begin
         if (n <= 50)       exp = PH_G;
         else if (n <= 110) exp = PH_E;
         else if (n <= 190) exp = PH_R;
         else if (n <= 290) exp = PH_G;
         else               exp = PH_Y;
         checkCount++;
         if ({traffic, pedestrian_light, emergency_light} !== exp) begin
            errorCount++;
            $display("[TB] FAIL emergency cycle %0d: got %b expected %b", n,
                     {traffic, pedestrian_light, emergency_light}, exp);
         end
         emergency_button = (n == 50);
         tick();
      end
      emergency_button = 1'b0;
   endtask

   task automatic test_ped_then_emg();
      logic [4:0] exp;
      do_reset();
      for (int n = 0; n <= 430; n++) begin
         if (n < 100)       exp = PH_G;
         else if (n <= 110) exp = PH_Y;
         else if (n <= 170) exp = PH_E;
         else if (n <= 250) exp = PH_R;
         else if (n <= 350) exp = PH_G;
         else if (n <= 370) exp = PH_Y;
         else if (n <= 420) exp = PH_P;
         else               exp = PH_G;
         checkCount++;
         if ({traffic, pedestrian_light, emergency_light} !== exp) begin
            errorCount++;
            $display("[TB] FAIL ped_then_emg cycle %0d: got %b expected %b", n,
                     {traffic, pedestrian_light, emergency_light}, exp);
         end
         pedestrian_button = (n == 10);
         emergency_button  = (n == 110);
         tick();
      end
      pedestrian_button = 1'b0;
      emergency_button  = 1'b0;
   endtask

   task automatic test_emg_extend();
      logic [4:0] exp;
      do_reset();
      for (int n = 0; n <= 230; n++) begin
         if (n <= 50)       exp = PH_G;
         else if (n <= 140) exp = PH_E;
         else if (n <= 220) exp = PH_R;
         else               exp = PH_G;
         checkCount++;
         if ({traffic, pedestrian_light, emergency_light} !== exp) begin
            errorCount++;
            $display("[TB] FAIL emg_extend cycle %0d: got %b expected %b", n,
                     {traffic, pedestrian_light, emergency_light}, exp);
         end
         emergency_button = (n == 50) || (n == 80);
         tick();
      end
      emergency_button = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic [4:0] exp;
      do_reset();
      for (int n = 0; n <= 340; n++) begin
         if (n <= 20)       exp = PH_G;
         else if (n <= 80)  exp = PH_E;
         else if (n <= 160) exp = PH_R;
         else if (n <= 260) exp = PH_G;
         else if (n <= 280) exp = PH_Y;
         else if (n <= 330) exp = PH_P;
         else               exp = PH_G;
         checkCount++;
         if ({traffic, pedestrian_light, emergency_light} !== exp) begin
            errorCount++;
            $display("[TB] FAIL simultaneous cycle %0d: got %b expected %b", n,
                     {traffic, pedestrian_light, emergency_light}, exp);
         end
         pedestrian_button = (n == 20);
         emergency_button  = (n == 20);
         tick();
      end
      pedestrian_button = 1'b0;
      emergency_button  = 1'b0;
   endtask

   // Second press lands on the very edge that enters PEDESTRIAN, so it must be served again.
   task automatic test_back_to_back();
      logic [4:0] exp;
      do_reset();
      for (int n = 0; n <= 345; n++) begin
         if (n < 100)      exp = PH_G;
         else if (n < 120) exp = PH_Y;
         else if (n < 170) exp = PH_P;
         else if (n < 270) exp = PH_G;
         else if (n < 290) exp = PH_Y;
         else if (n < 340) exp = PH_P;
         else              exp = PH_G;
         checkCount++;
         if ({traffic, pedestrian_light, emergency_light} !== exp) begin
            errorCount++;
            $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", n,
                     {traffic, pedestrian_light, emergency_light}, exp);
         end
         pedestrian_button = (n == 10) || (n == 119);
         tick();
      end
      pedestrian_button = 1'b0;
   endtask

   task automatic test_reset_midphase();
      logic [4:0] exp;
      do_reset();
      for (int n = 0; n <= 105; n++) begin
         exp = (n < 100) ? PH_G : PH_Y;
         checkCount++;
         if ({traffic, pedestrian_light, emergency_light} !== exp) begin
            errorCount++;
            $display("[TB] FAIL midphase_pre cycle %0d: got %b expected %b", n,
                     {traffic, pedestrian_light, emergency_light}, exp);
         end
         pedestrian_button = (n == 10);
         if (n < 105) tick();
      end
      pedestrian_button = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      checkCount++;
      if ({traffic, pedestrian_light, emergency_light} !== PH_G) begin
         errorCount++;
         $display("[TB] FAIL midphase_async: got %b expected %b",
                  {traffic, pedestrian_light, emergency_light}, PH_G);
      end
      tick();
      reset = 1'b1;
      for (int n = 0; n <= 200; n++) begin
         if (n < 100)      exp = PH_G;
         else if (n < 120) exp = PH_Y;
         else if (n < 200) exp = PH_R;
         else              exp = PH_G;
         checkCount++;
         if ({traffic, pedestrian_light, emergency_light} !== exp) begin
            errorCount++;
            $display("[TB] FAIL midphase_post cycle %0d: got %b expected %b", n,
                     {traffic, pedestrian_light, emergency_light}, exp);
         end
         tick();
      end
   endtask

   initial begin
      checkCount        = 0;
      errorCount        = 0;
      reset             = 1'b0;
      pedestrian_button = 1'b0;
      emergency_button  = 1'b0;
      $display("[TB] traffic_light_fsm directed tests starting");
      test_reset();
      test_nominal();
      test_pedestrian();
      test_emergency();
      test_ped_then_emg();
      test_emg_extend();
      test_simultaneous();
      test_back_to_back();
      test_reset_midphase();
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
